// File: rtl/alu_flag_register.sv
// alu_flag_register: registered N/Z/C/V status flags for ADD/SUB results, with sticky overflow and optional overflow counter
//
// Optional feature macro: FLAG_OVF_COUNT_EN (saturating overflow event counter; ovf_count tied to 0 when undefined)
//
// Ports:
//   clk             rising-edge clock
//   rst_n           asynchronous active-low reset
//   valid_i         opcode/operands/result valid this cycle
//   opcode          ALU operation (alu_ops encoding)
//   operand_a/b     ALU operands
//   op_result       ALU result as produced by the datapath
//   flag_clear      synchronous clear of flags, sticky bit and counter
//   valid_o         flags were updated from the previous cycle's valid_i
//   negative/zero/carry/overflow  registered N/Z/C/V
//   sticky_overflow set by any V=1 update, held until flag_clear or reset
//   ovf_count       saturating count of V=1 updates
package alu_ops;
  typedef enum logic [3:0] {
    ADD_OP = 4'h0,
    SUB_OP = 4'h1,
    AND_OP = 4'h2,
    OR_OP  = 4'h3,
    XOR_OP = 4'h4
  } op_e;
endpackage

module alu_flag_register #(
  parameter int W        = 4,
  parameter int OPW      = 4,
  parameter int LOGIC_NZ = 0,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             valid_i,
  input  logic [OPW-1:0]   opcode,
  input  logic [W-1:0]     operand_a,
  input  logic [W-1:0]     operand_b,
  input  logic [W-1:0]     op_result,
  input  logic             flag_clear,
  output logic             valid_o,
  output logic             negative,
  output logic             zero,
  output logic             carry,
  output logic             overflow,
  output logic             sticky_overflow,
  output logic [CNT_W-1:0] ovf_count
);
  logic is_add, is_sub, nz_en, a_s, b_s, r_s, n_nx, z_nx, c_nx, v_nx;
  always_comb begin
    is_add = opcode == OPW'(alu_ops::ADD_OP);
    is_sub = opcode == OPW'(alu_ops::SUB_OP);
    nz_en  = is_add || is_sub || LOGIC_NZ != 0;
    a_s    = operand_a[W-1];
    b_s    = operand_b[W-1];
    r_s    = op_result[W-1];
    n_nx   = nz_en && r_s;
    z_nx   = nz_en && op_result == '0;
    // a + b carries out of W bits exactly when a exceeds (2^W-1) - b, i.e. ~b
    c_nx   = is_add ? operand_a > ~operand_b : is_sub ? operand_a >= operand_b : 1'b0;
    v_nx   = is_add ? a_s == b_s && r_s != a_s : is_sub ? a_s != b_s && r_s != a_s : 1'b0;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_o         <= 1'b0;
      negative        <= 1'b0;
      zero            <= 1'b0;
      carry           <= 1'b0;
      overflow        <= 1'b0;
      sticky_overflow <= 1'b0;
    end else begin
      valid_o <= valid_i;
      if (valid_i) begin
        negative        <= n_nx;
        zero            <= z_nx;
        carry           <= c_nx;
        overflow        <= v_nx;
        sticky_overflow <= v_nx || (sticky_overflow && !flag_clear);
      end else if (flag_clear) begin
        negative        <= 1'b0;
        zero            <= 1'b0;
        carry           <= 1'b0;
        overflow        <= 1'b0;
        sticky_overflow <= 1'b0;
      end
    end
  end
`ifdef FLAG_OVF_COUNT_EN
  logic [CNT_W-1:0] cnt;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt <= '0;
    else if (flag_clear) cnt <= (valid_i && v_nx) ? CNT_W'(1) : '0;
    else if (valid_i && v_nx && cnt != '1) cnt <= cnt + 1'b1;
  end
  assign ovf_count = cnt;
`else
  assign ovf_count = '0;
`endif
endmodule

// File: tb/tb_alu_flag_register.sv
// tb_alu_flag_register: random + directed check of alu_flag_register against an arithmetic reference model
module tb_alu_flag_register;
  logic clk = 1'b0, rst_n = 1'b0, valid_i = 1'b0, flag_clear = 1'b0;
  logic [3:0] opcode = '0, operand_a = '0, operand_b = '0, op_result = '0;
  logic [1:0] vo, ng, zr, cy, ov, st;
  logic [1:0] cnt [2];
  int total = 0, bad = 0;
  always #5 clk = ~clk;
  for (genvar g = 0; g < 2; g++) begin : g_dut
    alu_flag_register #(.W(4), .OPW(4), .LOGIC_NZ(g), .CNT_W(2)) dut (
      .clk(clk), .rst_n(rst_n), .valid_i(valid_i), .opcode(opcode),
      .operand_a(operand_a), .operand_b(operand_b), .op_result(op_result),
      .flag_clear(flag_clear), .valid_o(vo[g]), .negative(ng[g]), .zero(zr[g]),
      .carry(cy[g]), .overflow(ov[g]), .sticky_overflow(st[g]), .ovf_count(cnt[g])
    );
  end
  function automatic int cnt_exp(int k);
`ifdef FLAG_OVF_COUNT_EN
    return k;
`else
    return 0;
`endif
  endfunction
  task automatic chk(string nm, int k, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s[dut%0d] t=%0t got=%0d want=%0d", nm, k, $time, act, exp);
    end
  endtask
  // reference model: flags from signed/unsigned integer arithmetic
  bit m_v, m_c, m_o, m_s;
  bit [1:0] m_n, m_z;
  int m_cnt, ma, mb, mr, sa, sb, sd;
  bit m_ar, c_new, o_new;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_v = 0; m_n = 0; m_z = 0; m_c = 0; m_o = 0; m_s = 0; m_cnt = 0;
    end else begin
      ma = operand_a; mb = operand_b; mr = op_result;
      sa = ma > 7 ? ma - 16 : ma;
      sb = mb > 7 ? mb - 16 : mb;
      m_ar = opcode < 2;
      sd = opcode == 0 ? sa + sb : sa - sb;
      c_new = opcode == 0 ? ma + mb > 15 : opcode == 1 ? ma >= mb : 1'b0;
      o_new = m_ar && (sd > 7 || sd < -8);
      m_v = valid_i;
      if (valid_i) begin
        for (int k = 0; k < 2; k++) begin
          m_n[k] = (m_ar || k == 1) && mr > 7;
          m_z[k] = (m_ar || k == 1) && mr == 0;
        end
        m_c = c_new; m_o = o_new;
        m_s = o_new || (m_s && !flag_clear);
        m_cnt = flag_clear ? int'(o_new) : (o_new && m_cnt < 3) ? m_cnt + 1 : m_cnt;
      end else if (flag_clear) begin
        m_n = 0; m_z = 0; m_c = 0; m_o = 0; m_s = 0; m_cnt = 0;
      end
    end
  end
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      chk("valid_o", k, vo[k], m_v);
      chk("negative", k, ng[k], m_n[k]);
      chk("zero", k, zr[k], m_z[k]);
      chk("carry", k, cy[k], m_c);
      chk("overflow", k, ov[k], m_o);
      chk("sticky", k, st[k], m_s);
      chk("ovf_count", k, cnt[k], cnt_exp(m_cnt));
    end
  end
  task automatic drive(int op, int a, int b, bit vi, bit fc, int lr = 0);
    opcode = 4'(op); operand_a = 4'(a); operand_b = 4'(b);
    valid_i = vi; flag_clear = fc;
    op_result = op == 0 ? 4'(a + b) : op == 1 ? 4'(a - b) : 4'(lr);
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  // literal pin: {valid_o, N, Z, C, V, sticky} plus counter
  task automatic lit(string nm, int k, int exp6, int expc);
    chk({nm, "_flags"}, k, {vo[k], ng[k], zr[k], cy[k], ov[k], st[k]}, exp6);
    chk({nm, "_cnt"}, k, cnt[k], cnt_exp(expc));
  endtask
  initial begin
    tick; tick;
    for (int k = 0; k < 2; k++) lit("reset", k, 6'b000000, 0);
    #2 rst_n = 1'b1;
    tick;
    drive(0, 7, 1, 1, 0); tick;
    for (int k = 0; k < 2; k++) lit("add7p1", k, 6'b110011, 1);
    drive(1, 3, 3, 1, 0); tick;
    for (int k = 0; k < 2; k++) lit("sub3m3", k, 6'b101101, 1);
    drive(0, 15, 1, 1, 0); tick;
    for (int k = 0; k < 2; k++) lit("add15p1", k, 6'b101101, 1);
    drive(0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      tick;
      for (int k = 0; k < 2; k++) lit("hold", k, 6'b001101, 1);
    end
    drive(1, 8, 1, 1, 0); tick;
    for (int k = 0; k < 2; k++) lit("sub8m1", k, 6'b100111, 2);
    drive(3, 0, 0, 1, 0, 9); tick;
    lit("or_lnz0", 0, 6'b100001, 2);
    lit("or_lnz1", 1, 6'b110001, 2);
    drive(0, 0, 0, 0, 1); tick;
    for (int k = 0; k < 2; k++) lit("clear", k, 6'b000000, 0);
    for (int i = 1; i <= 5; i++) begin
      drive(0, 7, 1, 1, 0); tick;
      for (int k = 0; k < 2; k++) lit("sat", k, 6'b110011, i < 3 ? i : 3);
    end
    drive(0, 7, 1, 1, 1); tick;
    for (int k = 0; k < 2; k++) lit("clr_add", k, 6'b110011, 1);
    drive(0, 0, 0, 0, 0);
    #1 rst_n = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) lit("async_rst", k, 6'b000000, 0);
    #1 rst_n = 1'b1;
    drive(1, 5, 2, 1, 0); tick;
    for (int k = 0; k < 2; k++) lit("post_rst", k, 6'b100100, 0);
    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15),
            $urandom_range(0, 3) != 0, $urandom_range(0, 9) == 0, $urandom_range(0, 15));
      if ($urandom_range(0, 99) == 0) begin
        #1 rst_n = 1'b0;
        #1 rst_n = 1'b1;
      end
      tick;
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/alu_flag_register.md
Name: alu_flag_register

Overview:
Parametrised, registered successor to the combinational ALU flag logic. It samples each valid ALU result and computes N, Z, C and V flags for alu_ops::ADD_OP and alu_ops::SUB_OP. Flags are held in a status register until the next valid update. It also keeps a sticky overflow bit and an optional saturating overflow event counter. It sits directly after the ALU datapath and feeds the status/condition logic.

Parameters:
W, 4, datapath width of operands and result (W >= 2)
OPW, 4, opcode width (matches alu_ops encoding)
LOGIC_NZ, 0, 1: non-arithmetic opcodes update N and Z from the result; 0: non-arithmetic opcodes clear all flags (legacy behaviour)
CNT_W, 8, overflow event counter width (used only with FLAG_OVF_COUNT_EN)

Ports:
clk  input  1  clock, all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
valid_i  input  1  opcode, operands and result are valid this cycle
opcode  input  OPW  ALU operation (alu_ops encoding)
operand_a  input  W  ALU operand A
operand_b  input  W  ALU operand B
op_result  input  W  ALU result (A+B or A-B, truncated to W)
flag_clear  input  1  synchronous clear of flags, sticky bit and counter
valid_o  output  1  flags updated from the previous cycle's valid_i
negative  output  1  registered N
zero  output  1  registered Z
carry  output  1  registered C
overflow  output  1  registered V
sticky_overflow  output  1  set by any V=1 update, held until flag_clear or reset
ovf_count  output  CNT_W  saturating count of V=1 updates

Behaviour:
- Reset (rst_n=0, asynchronous): valid_o, negative, zero, carry, overflow and sticky_overflow are 0; ovf_count is 0.
- Latency: an update presented with valid_i=1 in cycle n is visible on the flag outputs and valid_o=1 in cycle n+1.
- valid_i=0: N/Z/C/V hold their values; valid_o=0 next cycle.
- ADD_OP:
  - N = op_result[W-1]
  - Z = (op_result == 0)
  - C = bit W of the (W+1)-bit unsigned sum operand_a + operand_b
  - V = (a[W-1] == b[W-1]) && (op_result[W-1] != a[W-1])
- SUB_OP (A - B):
  - N and Z as for ADD_OP
  - C = (operand_a >= operand_b), unsigned; C=1 means no borrow
  - V = (a[W-1] != b[W-1]) && (op_result[W-1] != a[W-1])
- Other opcodes:
  - LOGIC_NZ=1: N and Z from op_result; C=0, V=0
  - LOGIC_NZ=0: N=Z=C=V=0
- N and Z always come from op_result as supplied; the block does not recompute the result. C and V use the operands.
- sticky_overflow: set in cycle n+1 when an update in cycle n produces V=1; never cleared by later V=0 updates.
- flag_clear without valid_i: N, Z, C, V, sticky_overflow and ovf_count go to 0 next cycle; valid_o=0.
- flag_clear with valid_i in the same cycle: the clear applies first, then the update.
  - N/Z/C/V take the new values and valid_o=1.
  - sticky_overflow = new V.
  - ovf_count = new V ? 1 : 0.
- Reset asserted mid-stream: all state clears immediately. The first valid_i after release behaves as a fresh update.
- Width rule: C is the only (W+1)-bit computation. All other compares are W bits wide.

Optional Feature:
FLAG_OVF_COUNT_EN
- Defined: ovf_count increments by 1 on each valid update with V=1 and saturates at 2^CNT_W-1 (no wrap). It is cleared by flag_clear and by reset.
- Not defined: the counter logic is absent, ovf_count is tied to 0, and the CNT_W parameter is ignored. All other behaviour is unchanged.

Test Plan (W=4, LOGIC_NZ=0 unless stated):
- ADD_OP, a=7, b=1, result=8 -> next cycle N=1, Z=0, C=0, V=1, sticky_overflow=1, valid_o=1.
- SUB_OP, a=3, b=3, result=0 -> N=0, Z=1, C=1, V=0; sticky_overflow unchanged from its prior value.
- ADD_OP, a=15, b=1, result=0, then valid_i=0 for 3 cycles -> Z=1, C=1, V=0, N=0 held for all 3 cycles; valid_o=1 then 0,0,0.
- SUB_OP, a=8, b=1, result=7 -> V=1, C=1, N=0. Then OR-type opcode with result=9: LOGIC_NZ=0 gives all flags 0; LOGIC_NZ=1 gives N=1, Z=0, C=0, V=0.
- FLAG_OVF_COUNT_EN, CNT_W=2: five consecutive ADD 7+1 -> ovf_count 1,2,3,3,3. Then flag_clear together with ADD 7+1 -> ovf_count=1, sticky_overflow=1.
- After a V=1 update, pulse rst_n low asynchronously between clock edges -> all outputs 0 immediately. After release, SUB 5-2 (result 3) -> N=0, Z=0, C=1, V=0, sticky_overflow=0.
